// File: rtl/bit_serializer_pkg.sv
// Shared constants for the bit serializer: state encoding and parameter defaults.
package bit_serializer_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_GAP   = 2;

  // IDLE=0, SHIFT=1, PAR=2, GAP=3
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial frame transmitter: MSB-first data, optional even-parity
// bit, then GAP idle cycles before the next LOAD can be accepted.
// Ports:
//   CLK     rising-edge clock
//   RESET   asynchronous active-low reset
//   LOAD    start request, sampled only in IDLE
//   DIN     parallel word, captured with LOAD
//   PAR_EN  append parity bit, captured with LOAD
//   X       serial data (registered)
//   VALID   X carries a frame bit (registered)
//   BUSY    frame in progress (registered)
//   DONE    one-cycle pulse after the last frame bit (registered)
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GAP   = DEF_GAP
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  input  logic             PAR_EN,
  output logic             X,
  output logic             VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_bit_q, par_bit_d;
  logic             par_en_q, par_en_d;
  logic             x_d, valid_d, busy_d, done_d;
  logic             end_frame;

  // State, datapath and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      X         <= 1'b0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      X         <= x_d;
      VALID     <= valid_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
    end
  end

  // Next-state and next-output logic; outputs computed one cycle ahead so
  // they leave the register bank aligned with the state they describe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    x_d       = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    end_frame = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        gap_d = '0;
        if (LOAD) begin
          // MSB goes out immediately; the rest waits in the shift register
          state_d   = ST_SHIFT;
          x_d       = DIN[WIDTH-1];
          shreg_d   = {DIN[WIDTH-2:0], 1'b0};
          par_bit_d = ^DIN;
          par_en_d  = PAR_EN;
          cnt_d     = CW'(1);
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        // cnt_q counts bits already on X; WIDTH means the last one is showing
        if (cnt_q < CW'(WIDTH)) begin
          x_d     = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (par_en_q) begin
          state_d = ST_PAR;
          x_d     = par_bit_q;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          end_frame = 1'b1;
        end
      end
      ST_PAR: begin
        end_frame = 1'b1;
      end
      ST_GAP: begin
        // gap_q numbers the idle cycle currently in progress, from 1
        if (gap_q < GW'(GAP)) begin
          gap_d  = gap_q + GW'(1);
          busy_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame tail: DONE marks the cycle right after the last frame bit
    if (end_frame) begin
      done_d = 1'b1;
      cnt_d  = '0;
      if (GAP > 0) begin
        state_d = ST_GAP;
        gap_d   = GW'(1);
        busy_d  = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

endmodule
